rtype_issue_ctrl: RTL and testbench
===================================

# rtype_issue_ctrl

Multi-cycle issue controller that sits upstream of the datapath ALU and produces its control inputs. It accepts one 32-bit MIPS R-type instruction per valid/ready handshake and decodes opcode, register fields, shamt and funct. It then drives the ALU's 6-bit function code, enable (alusrc) and operand-B select, captures the ALU result, and issues a single-cycle register-file writeback. It also flags unsupported encodings and keeps retire/illegal counters.

## Interface
- CNT_W, 16, width of the retired and illegal counters (saturating)
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- instr  in  32  instruction word; sampled on the accept cycle
- instr_valid  in  1  upstream has an instruction
- instr_ready  out  1  controller can accept; high only in IDLE
- rs_addr  out  5  register-file read port A address (instr[25:21])
- rt_addr  out  5  register-file read port B address (instr[20:16])
- alu_func  out  6  function code to ALU (instr[5:0] of the latched instruction)
- alu_src  out  1  ALU enable; high only in EXEC
- op_b_shamt  out  1  1 = ALU operand B is {27'b0, shamt} (shift ops), 0 = rt data
- shamt  out  5  instr[10:6] of the latched instruction
- alu_out  in  32  ALU result; sampled at the end of EXEC
- wb_en  out  1  one-cycle register-file write strobe
- wb_addr  out  5  destination register (instr[15:11])
- wb_data  out  32  captured ALU result
- illegal  out  1  one-cycle pulse: rejected instruction
- retired_cnt  out  CNT_W  count of instructions that reached WB
- illegal_cnt  out  CNT_W  count of illegal pulses

## Operation
- States: IDLE, DECODE, EXEC, WB.
- IDLE: instr_ready=1. If instr_valid, latch instr and go to DECODE. Otherwise stay.
- DECODE: rs_addr/rt_addr/shamt/op_b_shamt come from the latched word. Check legality:
  - opcode (instr[31:26]) must be 000000.
  - funct must be one of 100000 add, 100010 sub, 100100 and, 100101 or, 000000 sll, 000010 srl.
  - Legal: go to EXEC.
  - Illegal: go to IDLE, assert illegal for exactly the next cycle, and increment illegal_cnt.
- EXEC: alu_src=1 and alu_func=latched funct. op_b_shamt=1 for funct 000000/000010, else 0. On the exit edge, register wb_data<=alu_out. Go to WB.
- WB: wb_en=1 for this one cycle if rd!=0; rd==0 gives no write strobe but still retires. Increment retired_cnt. Go to IDLE.
- Counters saturate at all-ones; they do not wrap.
- alu_func, rs_addr, rt_addr, wb_addr, shamt and wb_data hold their last latched values outside their active states.
- Reset values:
  - State=IDLE.
  - instr_ready=1.
  - alu_src=0, wb_en=0, illegal=0, op_b_shamt=0.
  - All address, func, shamt, data and counter outputs = 0.

## Timing
- Accept at edge N (instr_valid & instr_ready).
- DECODE occupies cycle N+1.
- EXEC occupies cycle N+2; alu_src=1 there.
- WB occupies cycle N+3; wb_en=1 there.
- instr_ready returns high in cycle N+4.
- Throughput is one instruction per 4 cycles.
- Illegal path: the illegal pulse and instr_ready=1 both occur in cycle N+2.
- instr is ignored while instr_ready=0. Upstream holds it and the controller does not consume it.
- instr_valid high in the same cycle as illegal (back-to-back) is accepted normally.
- Asynchronous reset in any state: immediately forces IDLE and reset values. A pending WB is discarded (no wb_en), the instruction is lost, and counters clear.
- The ALU is combinational, so alu_out must be valid within the EXEC cycle. wb_data reflects the EXEC-cycle result, not later ALU changes.

## Test plan
- Reset then add: instr=0x01095020 (add $10,$8,$9), alu_out=0x0000_0007 in EXEC. Required:
  - rs=8, rt=9.
  - alu_func=100000 and alu_src=1 at N+2.
  - wb_en=1, wb_addr=10, wb_data=0x7 at N+3.
  - retired_cnt=1.
- Shift: instr=0x00094080 (sll $8,$9,2). Required: op_b_shamt=1 and shamt=2 in EXEC, alu_func=000000, wb_addr=8.
- Illegal: instr=0x8D090004 (lw). Required:
  - Cycle N+2: illegal=1, instr_ready=1.
  - No alu_src and no wb_en.
  - illegal_cnt=1.
- rd=0: instr=0x01090020 (add $0,$8,$9). Required: alu_src pulse, no wb_en, retired_cnt increments.
- Back-to-back: instr_valid held high with 3 legal instructions. Required: accepts exactly every 4 cycles and wb_en at N+3, N+7, N+11.
- Reset mid-op: assert rst_n=0 during EXEC. Required: outputs return to reset values immediately, no wb_en follows, and the next instruction after release completes normally.

Source files
------------

// File: rtl/rtype_issue_ctrl.sv
// Purpose: issue controller for MIPS R-type instructions; decodes, drives ALU control, writes back result.
// Latency: accept at N, DECODE N+1, EXEC N+2 (alu_src), WB N+3 (wb_en), ready again N+4; illegal pulse at N+2.
// Backpressure: instr_ready is high only in IDLE; instr/instr_valid are ignored while busy.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   instr, instr_valid/ready   instruction handshake (one word per accept)
//   rs_addr, rt_addr           register-file read addresses from the latched word
//   alu_func, alu_src          ALU function code and enable (enable high only in EXEC)
//   op_b_shamt, shamt          operand-B select (1 = shift amount) and shift amount
//   alu_out                    combinational ALU result, captured at the end of EXEC
//   wb_en, wb_addr, wb_data    one-cycle register-file write port
//   illegal                    one-cycle pulse for a rejected instruction
//   retired_cnt, illegal_cnt   saturating event counters
module rtype_issue_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [4:0]       rs_addr,
    output logic [4:0]       rt_addr,
    output logic [5:0]       alu_func,
    output logic             alu_src,
    output logic             op_b_shamt,
    output logic [4:0]       shamt,
    input  logic [31:0]      alu_out,
    output logic             wb_en,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic             illegal,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] illegal_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } state_t;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    state_t state;
    logic   legal_q;    // legality of the latched word, consumed in DECODE

    logic   in_legal;
    logic   in_shift;

    // Classification of the incoming word; only registered on the accept edge.
    always_comb begin
        in_shift = (instr[5:0] == FN_SLL) || (instr[5:0] == FN_SRL);
        in_legal = 1'b0;
        if (instr[31:26] == 6'b000000) begin
            case (instr[5:0])
                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLL, FN_SRL: in_legal = 1'b1;
                default:                                       in_legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            legal_q     <= 1'b0;
            instr_ready <= 1'b1;
            rs_addr     <= '0;
            rt_addr     <= '0;
            alu_func    <= '0;
            alu_src     <= 1'b0;
            op_b_shamt  <= 1'b0;
            shamt       <= '0;
            wb_en       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            illegal     <= 1'b0;
            retired_cnt <= '0;
            illegal_cnt <= '0;
        end else begin
            illegal <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        // Field registers double as the held outputs until the next accept.
                        rs_addr     <= instr[25:21];
                        rt_addr     <= instr[20:16];
                        wb_addr     <= instr[15:11];
                        shamt       <= instr[10:6];
                        alu_func    <= instr[5:0];
                        legal_q     <= in_legal;
                        op_b_shamt  <= in_legal && in_shift;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (legal_q) begin
                        alu_src <= 1'b1;
                        state   <= EXEC;
                    end else begin
                        illegal     <= 1'b1;
                        instr_ready <= 1'b1;
                        if (illegal_cnt != '1)
                            illegal_cnt <= illegal_cnt + CNT_W'(1);
                        state       <= IDLE;
                    end
                end
                EXEC: begin
                    alu_src <= 1'b0;
                    wb_data <= alu_out;
                    // Writes to $0 are suppressed but the instruction still retires.
                    wb_en   <= (wb_addr != 5'd0);
                    state   <= WB;
                end
                WB: begin
                    wb_en       <= 1'b0;
                    instr_ready <= 1'b1;
                    if (retired_cnt != '1)
                        retired_cnt <= retired_cnt + CNT_W'(1);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtype_issue_ctrl.sv
module tb_rtype_issue_ctrl;

    // Narrow counters so saturation is reachable in a short run.
    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr;
    logic          instr_valid;
    logic          instr_ready;
    logic [4:0]    rs_addr;
    logic [4:0]    rt_addr;
    logic [5:0]    alu_func;
    logic          alu_src;
    logic          op_b_shamt;
    logic [4:0]    shamt;
    logic [31:0]   alu_out;
    logic          wb_en;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic          illegal;
    logic [CW-1:0] retired_cnt;
    logic [CW-1:0] illegal_cnt;

    always #5 clk = ~clk;

    rtype_issue_ctrl #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .alu_func    (alu_func),
        .alu_src     (alu_src),
        .op_b_shamt  (op_b_shamt),
        .shamt       (shamt),
        .alu_out     (alu_out),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .retired_cnt (retired_cnt),
        .illegal_cnt (illegal_cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: expected counter values.
    int exp_ret = 0;
    int exp_ill = 0;

    logic [5:0] legal_funct [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd0, 6'd2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit ref_legal(input logic [31:0] w);
        bit hit = 0;
        foreach (legal_funct[i])
            if (legal_funct[i] == w[5:0]) hit = 1;
        return (w[31:26] == 6'd0) && hit;
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    task automatic chk_reset(input string p);
        chk({p, "_ready"},   instr_ready, 1);
        chk({p, "_alusrc"},  alu_src, 0);
        chk({p, "_wben"},    wb_en, 0);
        chk({p, "_illegal"}, illegal, 0);
        chk({p, "_opb"},     op_b_shamt, 0);
        chk({p, "_rs"},      rs_addr, 0);
        chk({p, "_rt"},      rt_addr, 0);
        chk({p, "_func"},    alu_func, 0);
        chk({p, "_shamt"},   shamt, 0);
        chk({p, "_wbaddr"},  wb_addr, 0);
        chk({p, "_wbdata"},  wb_data, 0);
        chk({p, "_retcnt"},  retired_cnt, 0);
        chk({p, "_illcnt"},  illegal_cnt, 0);
    endtask

    // One full transaction starting in an IDLE cycle. b2b keeps instr_valid
    // high (with junk on instr while busy) so the next call accepts at once.
    task automatic run(input logic [31:0] w, input logic [31:0] res, input bit b2b);
        bit         lg;
        bit         shift;
        logic [4:0] rd;
        lg    = ref_legal(w);
        shift = (w[5:0] == 6'd0) || (w[5:0] == 6'd2);
        rd    = w[15:11];

        instr       = w;
        instr_valid = 1'b1;
        chk("idle_ready", instr_ready, 1);
        tick();                                   // DECODE
        if (b2b) instr = $urandom;
        else     instr_valid = 1'b0;
        chk("dec_ready",   instr_ready, 0);
        chk("dec_rs",      rs_addr, w[25:21]);
        chk("dec_rt",      rt_addr, w[20:16]);
        chk("dec_illegal", illegal, 0);
        chk("dec_alusrc",  alu_src, 0);
        chk("dec_wben",    wb_en, 0);
        tick();
        if (!lg) begin                            // back in IDLE with pulse
            exp_ill = sat_inc(exp_ill);
            chk("ill_pulse",  illegal, 1);
            chk("ill_ready",  instr_ready, 1);
            chk("ill_alusrc", alu_src, 0);
            chk("ill_wben",   wb_en, 0);
            chk("ill_cnt",    illegal_cnt, exp_ill);
            chk("ill_retcnt", retired_cnt, exp_ret);
            if (!b2b) begin
                tick();
                chk("ill_pulse_end", illegal, 0);
                chk("ill_wben2",     wb_en, 0);
            end
            return;
        end
        alu_out = res;                            // EXEC
        chk("ex_alusrc", alu_src, 1);
        chk("ex_func",   alu_func, w[5:0]);
        chk("ex_opb",    op_b_shamt, shift);
        chk("ex_shamt",  shamt, w[10:6]);
        chk("ex_ready",  instr_ready, 0);
        chk("ex_wben",   wb_en, 0);
        tick();                                   // WB
        alu_out = $urandom;
        chk("wb_en",     wb_en, (rd != 5'd0));
        chk("wb_addr",   wb_addr, rd);
        chk("wb_data",   wb_data, res);
        chk("wb_alusrc", alu_src, 0);
        chk("wb_ready",  instr_ready, 0);
        exp_ret = sat_inc(exp_ret);
        tick();                                   // IDLE
        chk("post_ready",  instr_ready, 1);
        chk("post_wben",   wb_en, 0);
        chk("post_retcnt", retired_cnt, exp_ret);
        chk("post_illcnt", illegal_cnt, exp_ill);
        chk("post_wbdata", wb_data, res);
        chk("post_func",   alu_func, w[5:0]);
    endtask

    initial begin
        logic [31:0] w;
        rst_n       = 1'b0;
        instr       = '0;
        instr_valid = 1'b0;
        alu_out     = '0;
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed cases
        run(32'h0109_5020, 32'h0000_0007, 1'b0);  // add $10,$8,$9
        run(32'h0009_4080, 32'h0000_0024, 1'b0);  // sll $8,$9,2
        run(32'h8D09_0004, 32'h0,         1'b0);  // lw -> illegal
        run(32'h0109_0020, 32'h0000_0011, 1'b0);  // add $0,$8,$9
        run(32'h012A_5822, 32'hDEAD_BEEF, 1'b1);  // back-to-back x3
        run(32'h014B_6024, 32'h1234_5678, 1'b1);
        run(32'h0010_4882, 32'h0000_0003, 1'b0);
        run(32'hFC00_0020, 32'h0,         1'b1);  // illegal opcode, then accept at once
        run(32'h0128_5025, 32'hA5A5_A5A5, 1'b0);

        // Reset during EXEC
        instr       = 32'h0109_5020;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("mid_alusrc", alu_src, 1);
        rst_n = 1'b0;
        #1;
        chk_reset("midrst");
        exp_ret = 0;
        exp_ill = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_rst_wben",  wb_en, 0);
            chk("after_rst_ready", instr_ready, 1);
        end
        run(32'h0109_5020, 32'h0000_1234, 1'b0);

        // Randomized transactions; long enough to saturate both counters.
        for (int n = 0; n < 70; n++) begin
            if ($urandom_range(3, 0) != 3) begin
                w = $urandom;
                w[31:26] = 6'd0;
                w[5:0]   = legal_funct[$urandom_range(5, 0)];
                if ($urandom_range(4, 0) == 0) w[15:11] = 5'd0;
            end else begin
                w = $urandom;
                if ($urandom_range(1, 0) == 0) w[31:26] = 6'd0;
            end
            run(w, $urandom, ($urandom_range(3, 0) == 0));
        end
        instr_valid = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
